// File: rtl/hdlc_tx_framer.sv
// rtl/hdlc_tx_framer.sv - HDLC transmit framer with flags, zero-bit stuffing, abort and underrun handling
// Ports:
//   Clk             - sole clock, rising edge
//   Rst             - asynchronous active-high reset
//   Tx_Data         - payload byte, sent LSB first
//   Tx_DataLast     - Tx_Data is the last byte of the frame
//   Tx_DataValid    - byte offered
//   Tx_DataReady    - holding buffer can accept a byte
//   Tx_AbortFrame   - request abort of the frame in flight
//   Tx              - registered serial line, idles high
//   Tx_ValidFrame   - high while Tx carries data or stuffed bits
//   Tx_AbortedTrans - one-cycle pulse when an abort is taken
//   Tx_Done         - one-cycle pulse after the closing flag
module hdlc_tx_framer (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_DataLast,
    input  logic       Tx_DataValid,
    output logic       Tx_DataReady,
    input  logic       Tx_AbortFrame,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Done
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_FLAG = 3'd1,
        DATA       = 3'd2,
        STUFF      = 3'd3,
        END_FLAG   = 3'd4,
        ABORT      = 3'd5
    } state_t;

    state_t     state, stateNext;
    logic       txReg, txNext;
    logic [7:0] shReg, shNext;
    logic [2:0] bitCnt, bitNext;      // bit position within a flag or data byte
    logic [2:0] onesCnt, onesNext;    // consecutive data ones, including the bit on Tx
    logic       lastByte, lastNext;
    logic [7:0] bufData, bufDataNext;
    logic       bufLast, bufLastNext;
    logic       bufFull, bufFullNext;
    logic [1:0] abortDly, abortDlyNext; // 1,2: abort taken, frame still running its two trailing bits
    logic [3:0] abCnt, abCntNext;     // 0,1: idle-level fill after underrun; 2..9: abort pattern
    logic       abortedReg, abortedNext;
    logic       doneReg, doneNext;

    logic       advData, byteEnd, loadByte, underrun, frameState;
    logic [2:0] nextIdx;

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            txReg      <= 1'b1;
            shReg      <= 8'h00;
            bitCnt     <= 3'd0;
            onesCnt    <= 3'd0;
            lastByte   <= 1'b0;
            bufData    <= 8'h00;
            bufLast    <= 1'b0;
            bufFull    <= 1'b0;
            abortDly   <= 2'd0;
            abCnt      <= 4'd0;
            abortedReg <= 1'b0;
            doneReg    <= 1'b0;
        end else begin
            state      <= stateNext;
            txReg      <= txNext;
            shReg      <= shNext;
            bitCnt     <= bitNext;
            onesCnt    <= onesNext;
            lastByte   <= lastNext;
            bufData    <= bufDataNext;
            bufLast    <= bufLastNext;
            bufFull    <= bufFullNext;
            abortDly   <= abortDlyNext;
            abCnt      <= abCntNext;
            abortedReg <= abortedNext;
            doneReg    <= doneNext;
        end
    end

    // Next-state logic; Tx is computed together with the state so it is registered
    always_comb begin
        stateNext    = state;
        txNext       = txReg;
        shNext       = shReg;
        bitNext      = bitCnt;
        onesNext     = onesCnt;
        lastNext     = lastByte;
        bufDataNext  = bufData;
        bufLastNext  = bufLast;
        bufFullNext  = bufFull;
        abortDlyNext = abortDly;
        abCntNext    = abCnt;
        abortedNext  = 1'b0;
        doneNext     = 1'b0;
        advData      = 1'b0;
        byteEnd      = 1'b0;
        loadByte     = 1'b0;
        underrun     = 1'b0;
        nextIdx      = bitCnt + 3'd1;
        frameState   = (state == START_FLAG) || (state == DATA) ||
                       (state == STUFF) || (state == END_FLAG);

        if (Tx_DataValid && Tx_DataReady) begin
            bufDataNext = Tx_Data;
            bufLastNext = Tx_DataLast;
            bufFullNext = 1'b1;
        end

        case (state)
            IDLE: begin
                txNext   = 1'b1;
                onesNext = 3'd0;
                if (bufFull) begin
                    stateNext = START_FLAG;
                    bitNext   = 3'd0;
                    txNext    = 1'b0;
                end
            end
            START_FLAG: begin
                if (bitCnt == 3'd7) begin
                    loadByte = 1'b1;
                end else begin
                    bitNext = nextIdx;
                    txNext  = (nextIdx != 3'd7);   // 0x7E: only positions 0 and 7 are zero
                end
            end
            DATA: begin
                if (onesCnt == 3'd5) begin
                    stateNext = STUFF;
                    txNext    = 1'b0;
                    onesNext  = 3'd0;
                end else if (bitCnt != 3'd7) begin
                    advData = 1'b1;
                end else begin
                    byteEnd = 1'b1;
                end
            end
            STUFF: begin
                if (bitCnt != 3'd7) advData = 1'b1;
                else                byteEnd = 1'b1;
            end
            END_FLAG: begin
                if (bitCnt == 3'd7) begin
                    doneNext = (abortDly == 2'd0);
                    onesNext = 3'd0;
                    if (bufFull) begin
                        stateNext = START_FLAG;
                        bitNext   = 3'd0;
                        txNext    = 1'b0;
                    end else begin
                        stateNext = IDLE;
                        txNext    = 1'b1;
                    end
                end else begin
                    bitNext = nextIdx;
                    txNext  = (nextIdx != 3'd7);
                end
            end
            ABORT: begin
                if (abCnt == 4'd9) begin
                    stateNext = IDLE;
                    txNext    = 1'b1;
                end else begin
                    abCntNext = abCnt + 4'd1;
                    txNext    = ((abCnt + 4'd1) != 4'd2);
                end
            end
            default: begin
                stateNext = IDLE;
                txNext    = 1'b1;
            end
        endcase

        if (advData) begin
            stateNext = DATA;
            bitNext   = nextIdx;
            txNext    = shReg[nextIdx];
            onesNext  = shReg[nextIdx] ? onesCnt + 3'd1 : 3'd0;
        end

        if (byteEnd) begin
            if (lastByte) begin
                stateNext = END_FLAG;
                bitNext   = 3'd0;
                txNext    = 1'b0;
                onesNext  = 3'd0;
            end else if (bufFull || abortDly != 2'd0) begin
                // While an abort is pending the frame only needs filler bits until ABORT
                loadByte = 1'b1;
            end else begin
                underrun    = 1'b1;
                stateNext   = ABORT;
                abCntNext   = 4'd0;
                txNext      = 1'b1;
                onesNext    = 3'd0;
                abortedNext = 1'b1;
            end
        end

        if (loadByte) begin
            stateNext   = DATA;
            shNext      = bufData;
            lastNext    = bufLast;
            bitNext     = 3'd0;
            txNext      = bufData[0];
            onesNext    = bufData[0] ? onesCnt + 3'd1 : 3'd0;
            bufFullNext = 1'b0;
        end

        if (underrun) bufFullNext = 1'b0;

        if (Tx_AbortFrame && frameState && abortDly == 2'd0 && !underrun) begin
            abortedNext  = 1'b1;
            abortDlyNext = 2'd1;
            bufFullNext  = 1'b0;
        end else if (abortDly == 2'd1) begin
            abortDlyNext = 2'd2;
        end else if (abortDly == 2'd2) begin
            stateNext    = ABORT;
            abCntNext    = 4'd2;
            txNext       = 1'b0;
            onesNext     = 3'd0;
            abortDlyNext = 2'd0;
            bufFullNext  = 1'b0;
            doneNext     = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        Tx              = txReg;
        Tx_AbortedTrans = abortedReg;
        Tx_Done         = doneReg;
        Tx_ValidFrame   = (state == DATA) || (state == STUFF);
        Tx_DataReady    = !bufFull && (state != ABORT) && (abortDly == 2'd0);
    end

endmodule
